pixel_readout: RTL and testbench

Downstream consumer of the pixel phase sequencer. It captures the gray-coded pixel value bus once per read phase (read1..read4), converts it to binary, and tags it with pixel index and frame number. Tagged samples are buffered in a small FIFO and presented on a valid/ready stream to the array readout/serialiser. It also tracks frames on erase and flags dropped or truncated samples.

---
 rtl/pixel_pkg.sv | 14 +
 rtl/pixel_readout_fifo.sv | 41 ++++
 rtl/pixel_readout.sv | 136 +++++++++++++
 tb/tb_pixel_readout.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types, default widths and gray decoding for the pixel readout block
package pixel_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int FRAME_W_DEF = 4;
  typedef logic [1:0] pix_idx_t;
  typedef enum logic [1:0] {WAIT, SETTLE, CAPTURE, HOLD} state_t;
  // prefix XOR from the MSB; zero-extended gray decodes to zero-extended binary, so any width up to 32 works
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/pixel_readout_fifo.sv
// pixel_readout_fifo: synchronous FIFO with simultaneous push/pop, registered occupancy, no fall-through
module pixel_readout_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_c,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  assign dout = empty ? '0 : mem[rp];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  // storage needs no reset; empty gating hides stale contents
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: captures gray pixel values per read phase, tags them with index/frame and streams them out
module pixel_readout import pixel_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DELAY = 2,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               reset_c,
  input  logic               erase,
  input  logic               read1,
  input  logic               read2,
  input  logic               read3,
  input  logic               read4,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_idx,
  output logic [FRAME_W-1:0] out_frame,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               overflow,
  output logic               short_read,
  output logic               proto_err
);
  localparam int CW = $clog2(SAMPLE_DELAY) + 1;
  localparam int EW = FRAME_W + 2 + DATA_W;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  pix_idx_t idx, idx_n;
  logic [3:0] rd_q, rd_p, rise;
  logic erase_q, erase_p, erase_rise;
  logic [DATA_W-1:0] data_q;
  logic [FRAME_W-1:0] frame;
  logic multi, lat, other, push, drop, abort, perr, full, empty, pop;
  logic [EW-1:0] head;
  assign rise = rd_q & ~rd_p;
  assign erase_rise = erase_q & ~erase_p;
  assign multi = |(rd_q & (rd_q - 4'd1));
  assign lat = rd_q[idx];
  assign other = |(rise & ~(4'b0001 << idx));
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  assign {out_frame, out_idx, out_data} = head;
  // register inputs once and keep the previous copy for edge detection
  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      rd_q <= '0;
      rd_p <= '0;
      erase_q <= 1'b0;
      erase_p <= 1'b0;
      data_q <= '0;
    end else begin
      rd_q <= {read4, read3, read2, read1};
      rd_p <= rd_q;
      erase_q <= erase;
      erase_p <= erase_q;
      data_q <= data_in;
    end
  end
  // phase FSM: settle after a read rise, capture once, hold until the phase ends
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    push = 1'b0;
    drop = 1'b0;
    abort = 1'b0;
    perr = multi;
    if (multi) state_n = WAIT;
    else case (state)
      WAIT: if (|rise) begin
        state_n = SETTLE;
        cnt_n = CW'(SAMPLE_DELAY - 1);
        idx_n = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
      end
      SETTLE: begin
        perr = other;
        if (!lat) begin
          abort = 1'b1;
          state_n = WAIT;
        end else if (cnt == '0) state_n = CAPTURE;
        else cnt_n = cnt - CW'(1);
      end
      CAPTURE: begin
        perr = other;
        push = ~full | pop;
        drop = full & ~pop;
        state_n = HOLD;
      end
      HOLD: begin
        perr = other;
        state_n = lat ? HOLD : WAIT;
      end
      default: state_n = WAIT;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      state <= WAIT;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end
  // frame counter, sticky flags (erase clears, a same-cycle event re-sets) and frame_done pulse
  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      frame <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      short_read <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (erase_rise) frame <= frame + FRAME_W'(1);
      frame_done <= (push | drop | abort) & (idx == 2'd3);
      overflow <= (overflow & ~erase_rise) | drop;
      short_read <= (short_read & ~erase_rise) | abort;
      proto_err <= (proto_err & ~erase_rise) | perr;
    end
  end
  pixel_readout_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_c(reset_c),
    .push(push),
    .pop(pop),
    .din({frame, idx, DATA_W'(gray2bin(32'(data_q)))}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: directed scoreboard bench for pixel_readout
module tb_pixel_readout;
  typedef struct packed {
    logic [3:0] frame;
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic reset_c = 1'b1;
  logic erase = 1'b0;
  logic [3:0] rd = '0;
  logic [7:0] din = '0;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic [3:0] out_frame;
  logic out_valid, frame_done, overflow, short_read, proto_err;
  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int fd0;
  logic active;
  exp_t q[$];
  pixel_readout dut (
    .clk(clk), .reset_c(reset_c), .erase(erase),
    .read1(rd[0]), .read2(rd[1]), .read3(rd[2]), .read4(rd[3]),
    .data_in(din), .out_data(out_data), .out_idx(out_idx), .out_frame(out_frame),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .overflow(overflow), .short_read(short_read), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic exp_t mk(input int f, input int i, input int d);
    exp_t e;
    e.frame = 4'(f);
    e.idx = 2'(i);
    e.data = 8'(d);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic erase_pulse();
    erase = 1'b1;
    tick();
    erase = 1'b0;
    tick();
    tick();
  endtask
  task automatic read_pulse(input int n, input logic [7:0] v, input int hi);
    rd[n] = 1'b1;
    din = gray(v);
    repeat (hi) tick();
    rd = '0;
    tick();
    tick();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) fd_cnt++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("extra_beat", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_idx", out_idx, e.idx);
        chk("beat_frame", out_frame, e.frame);
      end
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_frame", out_frame, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_short", short_read, 0);
    chk("rst_proto", proto_err, 0);
    reset_c = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      active = active | out_valid | frame_done | overflow | short_read | proto_err;
    end
    chk("idle", active, 0);
    out_ready = 1'b1;
    rd[0] = 1'b1;
    din = 8'h0C;
    q.push_back(mk(0, 0, 8'h08));
    repeat (4) tick();
    chk("t1_not_early", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'h08);
    repeat (5) tick();
    rd = '0;
    repeat (3) tick();
    out_ready = 1'b0;
    erase_pulse();
    fd0 = fd_cnt;
    for (int n = 0; n < 4; n++) begin
      q.push_back(mk(1, n, 10 * (n + 1)));
      read_pulse(n, 8'(10 * (n + 1)), 10);
    end
    chk("fdone_once", fd_cnt - fd0, 1);
    chk("full_valid", out_valid, 1);
    chk("full_head_idx", out_idx, 0);
    chk("full_head_frame", out_frame, 1);
    chk("full_head_data", out_data, 10);
    chk("no_ovf_yet", overflow, 0);
    read_pulse(0, 8'd55, 10);
    chk("ovf_set", overflow, 1);
    chk("ovf_no_fdone", fd_cnt - fd0, 1);
    erase_pulse();
    chk("erase_clr_ovf", overflow, 0);
    rd[0] = 1'b1;
    din = gray(8'd50);
    q.push_back(mk(2, 0, 50));
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    rd = '0;
    repeat (3) tick();
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_head", out_idx, 1);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_empty", out_valid, 0);
    chk("drain_queue", q.size(), 0);
    out_ready = 1'b0;
    read_pulse(1, 8'd33, 1);
    repeat (3) tick();
    chk("short_set", short_read, 1);
    chk("short_no_push", out_valid, 0);
    rd = 4'b0101;
    repeat (3) tick();
    rd = '0;
    repeat (2) tick();
    chk("proto_set", proto_err, 1);
    chk("proto_no_push", out_valid, 0);
    erase_pulse();
    chk("erase_clr_short", short_read, 0);
    chk("erase_clr_proto", proto_err, 0);
    reset_c = 1'b1;
    tick();
    reset_c = 1'b0;
    tick();
    q.delete();
    for (int i = 0; i < 15; i++) erase_pulse();
    out_ready = 1'b1;
    q.push_back(mk(15, 0, 7));
    read_pulse(0, 8'd7, 10);
    out_ready = 1'b0;
    erase_pulse();
    fd0 = fd_cnt;
    q.push_back(mk(0, 3, 77));
    read_pulse(3, 8'd77, 10);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_frame", out_frame, 0);
    chk("wrap_idx", out_idx, 3);
    chk("wrap_data", out_data, 77);
    chk("wrap_fdone", fd_cnt - fd0, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("wrap_drained", q.size(), 0);
    out_ready = 1'b0;
    rd[0] = 1'b1;
    din = gray(8'd99);
    repeat (2) tick();
    reset_c = 1'b1;
    rd = '0;
    tick();
    reset_c = 1'b0;
    q.delete();
    repeat (12) tick();
    chk("midrst_empty", out_valid, 0);
    chk("midrst_short", short_read, 0);
    chk("midrst_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
